// File: rtl/sum_collect_pkg.sv
// Shared constants for the adder result collector: register map, CTRL/STATUS
// bit positions, entry width and a saturating counter helper.
package sum_collect_pkg;

    localparam int ENTRY_W = 9;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_ACC_LO    = 3'd2;
    localparam logic [2:0] ADDR_ACC_HI    = 3'd3;
    localparam logic [2:0] ADDR_DROP_CNT  = 3'd4;
    localparam logic [2:0] ADDR_CARRY_CNT = 3'd5;
    localparam logic [2:0] ADDR_THRESH    = 3'd6;
    localparam logic [2:0] ADDR_RSVD      = 3'd7;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_CLR   = 1;
    localparam int CTRL_FLUSH = 2;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_MSB = 4;
    localparam int STAT_COUNT_W   = STAT_COUNT_MSB - STAT_COUNT_LSB + 1;
    localparam int STAT_FULL      = 5;
    localparam int STAT_EMPTY     = 6;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with an extra pointer bit to separate full from empty.
// Flush overrides push and pop; a push into a full FIFO is taken only with a same-edge pop.
module result_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 9
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ENTRY_W-1:0]       wdata,
    output logic [ENTRY_W-1:0]       rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               pop_ok;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == DEPTH_CNT);
    assign pop_ok  = pop & ~flush & ~empty;
    assign push_ok = push & ~flush & (~full | pop_ok);

    // Head is read straight from storage; forced to zero when nothing is queued.
    assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sum_result_collector.sv
// Captures adder results into a FIFO, keeps acc/carry/drop statistics and
// exposes control and statistics over the 3-bit des_* register port.
module sum_result_collector
    import sum_collect_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int ACC_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         sum_result,
    input  logic               sum_carry,
    input  logic               data_ready,
    output logic [ENTRY_W-1:0] res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               thresh_irq,
    input  logic [2:0]         des_address,
    input  logic [7:0]         des_value,
    input  logic               des_req_valid,
    input  logic               des_wr_rd,
    output logic [7:0]         des_rd_value
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic             ctrl_en;
    logic [7:0]       thresh_q;
    logic [ACC_W-1:0] acc_q;
    logic [7:0]       drop_cnt;
    logic [7:0]       carry_cnt;

    logic             reg_wr;
    logic             reg_rd;
    logic             ctrl_wr;
    logic             clr_stats;
    logic             flush;
    logic             push_req;
    logic             push_ok;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic [STAT_COUNT_W-1:0] count5;
    logic [ENTRY_W-1:0] entry;
    logic [7:0]       status_word;
    logic [7:0]       rd_mux;

    assign reg_wr    = des_req_valid & des_wr_rd;
    assign reg_rd    = des_req_valid & ~des_wr_rd;
    assign ctrl_wr   = reg_wr & (des_address == ADDR_CTRL);
    assign clr_stats = ctrl_wr & des_value[CTRL_CLR];
    assign flush     = ctrl_wr & des_value[CTRL_FLUSH];

    // A flush on the same edge discards the incoming result silently (no drop).
    assign entry    = {sum_carry, sum_result};
    assign push_req = data_ready & ctrl_en & ~flush;
    assign drop     = push_req & ~push_ok;
    assign count5   = STAT_COUNT_W'(fifo_count);

    // Consumer handshake: res_valid is high whenever the FIFO holds an entry and
    // res_data is that head entry; the head is consumed on a clock edge where
    // res_valid & res_ready; res_ready while empty has no effect.
    assign res_valid = ~fifo_empty;

    result_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_req),
        .pop     (res_ready),
        .flush   (flush),
        .wdata   (entry),
        .rdata   (res_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .push_ok (push_ok)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en  <= 1'b1;
            thresh_q <= 8'h00;
        end else if (reg_wr) begin
            if (des_address == ADDR_CTRL)   ctrl_en  <= des_value[CTRL_EN];
            if (des_address == ADDR_THRESH) thresh_q <= des_value;
        end
    end

    // Clear outranks a same-edge accepted push or drop.
    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            acc_q     <= '0;
            drop_cnt  <= 8'h00;
            carry_cnt <= 8'h00;
        end else begin
            if (push_ok) begin
                acc_q <= acc_q + ACC_W'(entry);
                if (sum_carry) carry_cnt <= sat_inc8(carry_cnt);
            end
            if (drop) drop_cnt <= sat_inc8(drop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thresh_irq <= 1'b0;
        end else begin
            thresh_irq <= (thresh_q[4:0] != 5'd0) && (count5 >= thresh_q[4:0]);
        end
    end

    always_comb begin
        status_word = 8'h00;
        status_word[STAT_COUNT_MSB:STAT_COUNT_LSB] = count5;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
    end

    always_comb begin
        rd_mux = 8'h00;
        case (des_address)
            ADDR_CTRL:      rd_mux[CTRL_EN] = ctrl_en;
            ADDR_STATUS:    rd_mux = status_word;
            ADDR_ACC_LO:    rd_mux = acc_q[7:0];
            ADDR_ACC_HI:    rd_mux = 8'(acc_q >> 8);
            ADDR_DROP_CNT:  rd_mux = drop_cnt;
            ADDR_CARRY_CNT: rd_mux = carry_cnt;
            ADDR_THRESH:    rd_mux = thresh_q;
            ADDR_RSVD:      rd_mux = 8'h00;
            default:        rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            des_rd_value <= 8'h00;
        end else if (reg_rd) begin
            des_rd_value <= rd_mux;
        end
    end

endmodule

// File: tb/tb_sum_result_collector.sv
// Bench for sum_result_collector: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_sum_result_collector;

    localparam int DEPTH = 8;
    localparam int ACC_W = 12;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sum_result;
    logic       sum_carry;
    logic       data_ready;
    logic [8:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic       thresh_irq;
    logic [2:0] des_address;
    logic [7:0] des_value;
    logic       des_req_valid;
    logic       des_wr_rd;
    logic [7:0] des_rd_value;

    int checks = 0;
    int errors = 0;

    sum_result_collector #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .sum_result    (sum_result),
        .sum_carry     (sum_carry),
        .data_ready    (data_ready),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .thresh_irq    (thresh_irq),
        .des_address   (des_address),
        .des_value     (des_value),
        .des_req_valid (des_req_valid),
        .des_wr_rd     (des_wr_rd),
        .des_rd_value  (des_rd_value)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0] exp_q[$];
    int         m_acc;
    int         m_drop;
    int         m_carry;
    bit         m_en;
    logic [7:0] m_thresh;
    logic [7:0] m_rd;
    bit         m_irq;
    bit         model_live = 0;

    function automatic logic [7:0] model_read(input logic [2:0] a);
        logic [7:0] v;
        int n;
        n = exp_q.size();
        case (a)
            3'd0: v = {7'd0, m_en};
            3'd1: v = {1'b0, n == 0, n == DEPTH, 5'(n)};
            3'd2: v = 8'(m_acc % 256);
            3'd3: v = 8'(m_acc / 256);
            3'd4: v = 8'(m_drop);
            3'd5: v = 8'(m_carry);
            3'd6: v = m_thresh;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        bit wr, flush, clr, push, pop, accept;
        if (reset) begin
            exp_q.delete();
            m_acc = 0; m_drop = 0; m_carry = 0;
            m_en = 1; m_thresh = 8'h00; m_rd = 8'h00; m_irq = 0;
            model_live = 1;
        end else if (model_live) begin
            wr = des_req_valid && des_wr_rd;
            if (des_req_valid && !des_wr_rd) m_rd = model_read(des_address);
            m_irq = (m_thresh[4:0] != 0) && (exp_q.size() >= int'(m_thresh[4:0]));
            flush = wr && des_address == 3'd0 && des_value[2];
            clr   = wr && des_address == 3'd0 && des_value[1];
            push  = data_ready && m_en && !flush;
            pop   = res_ready && exp_q.size() > 0;
            if (flush) begin
                exp_q.delete();
            end else begin
                accept = push && (exp_q.size() < DEPTH || pop);
                if (pop) void'(exp_q.pop_front());
                if (accept) begin
                    exp_q.push_back({sum_carry, sum_result});
                    m_acc = (m_acc + int'({sum_carry, sum_result})) % (1 << ACC_W);
                    if (sum_carry && m_carry < 255) m_carry++;
                end else if (push && m_drop < 255) begin
                    m_drop++;
                end
            end
            if (clr) begin
                m_acc = 0; m_drop = 0; m_carry = 0;
            end
            if (wr && des_address == 3'd0) m_en = des_value[0];
            if (wr && des_address == 3'd6) m_thresh = des_value;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("res_valid", 16'(res_valid), 16'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("res_data", 16'(res_data), 16'(exp_q[0]));
            check("thresh_irq", 16'(thresh_irq), 16'(m_irq));
            check("des_rd_value", 16'(des_rd_value), 16'(m_rd));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic reg_write(input logic [2:0] a, input logic [7:0] v);
        des_req_valid = 1; des_wr_rd = 1; des_address = a; des_value = v;
        @(negedge clk);
        des_req_valid = 0; des_wr_rd = 0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
        des_req_valid = 1; des_wr_rd = 0; des_address = a;
        @(negedge clk);
        des_req_valid = 0;
        d = des_rd_value;
    endtask

    task automatic read_expect(input string name, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        reg_read(a, d);
        check(name, 16'(d), 16'(exp));
    endtask

    logic [8:0] t1_vals [3];
    logic [8:0] exp_head;

    initial begin
        t1_vals[0] = 9'h163; t1_vals[1] = 9'h106; t1_vals[2] = 9'h03D;
        reset = 1; data_ready = 0; sum_result = 0; sum_carry = 0; res_ready = 0;
        des_address = 0; des_value = 0; des_req_valid = 0; des_wr_rd = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        check("reset_res_valid", 16'(res_valid), 16'h0);
        check("reset_irq", 16'(thresh_irq), 16'h0);
        check("reset_rd_value", 16'(des_rd_value), 16'h0);
        read_expect("reset_ctrl", 3'd0, 8'h01);
        read_expect("reset_status", 3'd1, 8'h40);

        // three results streamed with the consumer always ready
        res_ready = 1;
        for (int i = 0; i < 3; i++) begin
            {sum_carry, sum_result} = t1_vals[i];
            data_ready = 1;
            @(negedge clk);
            check("t1_head", 16'(res_data), 16'(t1_vals[i]));
        end
        data_ready = 0;
        @(negedge clk);
        read_expect("t1_acc_lo", 3'd2, 8'hA6);
        read_expect("t1_acc_hi", 3'd3, 8'h02);
        read_expect("t1_carry", 3'd5, 8'h02);

        // overfill with the consumer stalled
        reg_write(3'd0, 8'h03);
        res_ready = 0;
        {sum_carry, sum_result} = 9'h0AA;
        data_ready = 1;
        repeat (10) @(negedge clk);
        data_ready = 0;
        read_expect("t2_status", 3'd1, 8'h28);
        read_expect("t2_drop", 3'd4, 8'h02);
        read_expect("t2_acc_lo", 3'd2, 8'h50);
        read_expect("t2_acc_hi", 3'd3, 8'h05);

        // full FIFO: push and pop on the same edge
        {sum_carry, sum_result} = 9'h155;
        data_ready = 1; res_ready = 1;
        @(negedge clk);
        data_ready = 0; res_ready = 0;
        read_expect("t3_status", 3'd1, 8'h28);
        read_expect("t3_drop", 3'd4, 8'h02);
        read_expect("t3_acc_lo", 3'd2, 8'hA5);
        res_ready = 1;
        for (int i = 0; i < 8; i++) begin
            exp_head = (i == 7) ? 9'h155 : 9'h0AA;
            check("t3_drain", 16'(res_data), 16'(exp_head));
            @(negedge clk);
        end
        check("t3_empty", 16'(res_valid), 16'h0);

        // threshold interrupt timing
        reg_write(3'd0, 8'h03);
        reg_write(3'd6, 8'h03);
        res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            sum_result = 8'($urandom_range(0, 255)); sum_carry = 0; data_ready = 1;
            @(negedge clk);
        end
        data_ready = 0;
        check("t4_irq_lag", 16'(thresh_irq), 16'h0);
        @(negedge clk);
        check("t4_irq_rise", 16'(thresh_irq), 16'h1);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        check("t4_irq_hold", 16'(thresh_irq), 16'h1);
        @(negedge clk);
        check("t4_irq_fall", 16'(thresh_irq), 16'h0);

        // flush + clear on the same edge as a push, then disabled capture
        sum_result = 8'hFF; sum_carry = 1; data_ready = 1;
        reg_write(3'd0, 8'h07);
        data_ready = 0;
        read_expect("t5_status", 3'd1, 8'h40);
        read_expect("t5_acc_lo", 3'd2, 8'h00);
        read_expect("t5_drop", 3'd4, 8'h00);
        read_expect("t5_carry", 3'd5, 8'h00);
        read_expect("t5_ctrl", 3'd0, 8'h01);
        reg_write(3'd0, 8'h00);
        data_ready = 1;
        @(negedge clk);
        data_ready = 0;
        read_expect("t5_dis_status", 3'd1, 8'h40);
        read_expect("t5_dis_drop", 3'd4, 8'h00);
        reg_write(3'd0, 8'h01);

        // reset in the middle of traffic
        res_ready = 0;
        for (int i = 0; i < 5; i++) begin
            sum_result = 8'($urandom_range(0, 255)); sum_carry = 1'($urandom_range(0, 1));
            data_ready = 1;
            @(negedge clk);
        end
        data_ready = 0;
        read_expect("t6_status_pre", 3'd1, 8'h05);
        data_ready = 1; reset = 1;
        @(negedge clk);
        reset = 0; data_ready = 0;
        check("t6_res_valid", 16'(res_valid), 16'h0);
        check("t6_rd_value", 16'(des_rd_value), 16'h0);
        check("t6_irq", 16'(thresh_irq), 16'h0);
        read_expect("t6_status", 3'd1, 8'h40);
        read_expect("t6_ctrl", 3'd0, 8'h01);
        read_expect("t6_thresh", 3'd6, 8'h00);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            data_ready  = ($urandom_range(0, 9) < 7);
            sum_result  = 8'($urandom_range(0, 255));
            sum_carry   = 1'($urandom_range(0, 1));
            res_ready   = ((i / 400) % 2 == 1) ? ($urandom_range(0, 9) < 3)
                                               : ($urandom_range(0, 9) < 8);
            des_req_valid = ($urandom_range(0, 3) == 0);
            des_wr_rd     = ($urandom_range(0, 3) == 0);
            des_address   = 3'($urandom_range(0, 7));
            des_value     = 8'($urandom_range(0, 255));
            if (des_address == 3'd0) begin
                des_value[0] = ($urandom_range(0, 7) != 0);
                des_value[1] = ($urandom_range(0, 7) == 0);
                des_value[2] = ($urandom_range(0, 15) == 0);
            end
            if (des_address == 3'd6) des_value = 8'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        reset = 0; data_ready = 0; des_req_valid = 0; res_ready = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
